// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types, constants and helpers for the sprite_mover block.
// Optional feature macro: SPRITE_MOVER_WRAP_EN (edges wrap instead of bouncing).
package sprite_pkg;

  localparam int CORDW = 16;
  localparam int VELW  = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP_X = 2'd1,
    STEP_Y = 2'd2,
    COMMIT = 2'd3
  } mover_state_t;

  // Result of one single-axis step: new position, new velocity, edge event.
  typedef struct packed {
    logic signed [CORDW-1:0] pos;
    logic signed [VELW-1:0]  vel;
    logic                    hit;
  } axis_evt_t;

`ifdef SPRITE_MOVER_WRAP_EN
  localparam bit WRAP_MODE = 1'b1;
`else
  localparam bit WRAP_MODE = 1'b0;
`endif

  // Clamp a signed coordinate into 0..max.
  function automatic logic signed [CORDW-1:0] clamp_pos(
    input logic signed [CORDW-1:0] p,
    input logic signed [CORDW-1:0] max
  );
    if (p[CORDW-1]) begin
      clamp_pos = {CORDW{1'b0}};
    end else if (p > max) begin
      clamp_pos = max;
    end else begin
      clamp_pos = p;
    end
  endfunction

endpackage

// File: rtl/sprite_axis_step.sv
// sprite_axis_step: combinational single-axis position step with edge handling
// (bounce by default, wrap when SPRITE_MOVER_WRAP_EN is defined).
module sprite_axis_step
  import sprite_pkg::*;
(
  input  logic signed [CORDW-1:0] pos_i,
  input  logic signed [VELW-1:0]  vel_i,
  input  logic signed [CORDW-1:0] max_i,
  output axis_evt_t               evt_o
);

  localparam logic signed [VELW-1:0] VEL_MIN = {1'b1, {(VELW-1){1'b0}}};
  localparam logic signed [VELW-1:0] VEL_MAX = {1'b0, {(VELW-1){1'b1}}};

  logic signed [CORDW:0]   sum_s;
  logic signed [CORDW:0]   max_ext_s;
  logic signed [VELW-1:0]  vel_neg_s;

  // One extra bit of headroom so pos+vel can never overflow.
  assign sum_s     = {pos_i[CORDW-1], pos_i} + {{(CORDW+1-VELW){vel_i[VELW-1]}}, vel_i};
  assign max_ext_s = {max_i[CORDW-1], max_i};
  // Negating the most-negative velocity saturates instead of wrapping back to itself.
  assign vel_neg_s = (vel_i == VEL_MIN) ? VEL_MAX : -vel_i;

  // Classify the stepped position against the 0..max window.
  always_comb begin
    evt_o.pos = pos_i;
    evt_o.vel = vel_i;
    evt_o.hit = 1'b0;
    if (sum_s[CORDW]) begin
      evt_o.pos = WRAP_MODE ? max_i : {CORDW{1'b0}};
      evt_o.vel = WRAP_MODE ? vel_i : vel_neg_s;
      evt_o.hit = 1'b1;
    end else if (sum_s > max_ext_s) begin
      evt_o.pos = WRAP_MODE ? {CORDW{1'b0}} : max_i;
      evt_o.vel = WRAP_MODE ? vel_i : vel_neg_s;
      evt_o.hit = 1'b1;
    end else begin
      evt_o.pos = sum_s[CORDW-1:0];
      evt_o.vel = vel_i;
      evt_o.hit = 1'b0;
    end
  end

endmodule

// File: rtl/sprite_mover.sv
// sprite_mover: per-frame position controller for one hardware sprite.
// A single step unit is shared between X and Y; both axes commit together.
// Optional feature macro: SPRITE_MOVER_WRAP_EN (edges wrap instead of bouncing).
module sprite_mover
  import sprite_pkg::*;
#(
  parameter int H_RES     = 480,
  parameter int V_RES     = 272,
  parameter int SPR_W_PX  = 64,
  parameter int SPR_H_PX  = 64,
  parameter int FRAME_DIV = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame,
  input  logic                    en,
  input  logic                    load,
  input  logic signed [CORDW-1:0] init_x,
  input  logic signed [CORDW-1:0] init_y,
  input  logic signed [VELW-1:0]  init_dx,
  input  logic signed [VELW-1:0]  init_dy,
  output logic signed [CORDW-1:0] sprx,
  output logic signed [CORDW-1:0] spry,
  output logic signed [VELW-1:0]  dx,
  output logic signed [VELW-1:0]  dy,
  output logic                    bounce_x,
  output logic                    bounce_y,
  output logic                    busy
);

  localparam logic signed [CORDW-1:0] MAX_X = CORDW'(H_RES - SPR_W_PX);
  localparam logic signed [CORDW-1:0] MAX_Y = CORDW'(V_RES - SPR_H_PX);
  localparam int                      DIVW  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIVW-1:0]         DIV_LAST = DIVW'(FRAME_DIV - 1);

  mover_state_t            state_q;
  logic [DIVW-1:0]         div_q;
  logic signed [CORDW-1:0] sprx_q, spry_q;
  logic signed [VELW-1:0]  dx_q, dy_q;
  logic                    bounce_x_q, bounce_y_q, busy_q;
  axis_evt_t               shx_q, shy_q;

  logic signed [CORDW-1:0] step_pos_s, step_max_s;
  logic signed [VELW-1:0]  step_vel_s;
  axis_evt_t               step_d;

  // Route the axis being processed this cycle into the shared step unit.
  always_comb begin
    step_pos_s = spry_q;
    step_vel_s = dy_q;
    step_max_s = MAX_Y;
    if (state_q == STEP_X) begin
      step_pos_s = sprx_q;
      step_vel_s = dx_q;
      step_max_s = MAX_X;
    end else begin
      step_pos_s = spry_q;
      step_vel_s = dy_q;
      step_max_s = MAX_Y;
    end
  end

  sprite_axis_step u_step (
    .pos_i (step_pos_s),
    .vel_i (step_vel_s),
    .max_i (step_max_s),
    .evt_o (step_d)
  );

  // Update sequencer: load overrides everything; results sit in shadows until COMMIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      div_q      <= {DIVW{1'b0}};
      sprx_q     <= {CORDW{1'b0}};
      spry_q     <= {CORDW{1'b0}};
      dx_q       <= {VELW{1'b0}};
      dy_q       <= {VELW{1'b0}};
      bounce_x_q <= 1'b0;
      bounce_y_q <= 1'b0;
      busy_q     <= 1'b0;
      shx_q      <= '{pos: {CORDW{1'b0}}, vel: {VELW{1'b0}}, hit: 1'b0};
      shy_q      <= '{pos: {CORDW{1'b0}}, vel: {VELW{1'b0}}, hit: 1'b0};
    end else if (load) begin
      state_q    <= IDLE;
      div_q      <= {DIVW{1'b0}};
      sprx_q     <= clamp_pos(init_x, MAX_X);
      spry_q     <= clamp_pos(init_y, MAX_Y);
      dx_q       <= init_dx;
      dy_q       <= init_dy;
      bounce_x_q <= 1'b0;
      bounce_y_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      bounce_x_q <= 1'b0;
      bounce_y_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (frame) begin
            div_q <= (div_q == DIV_LAST) ? {DIVW{1'b0}} : div_q + 1'b1;
            if ((div_q == {DIVW{1'b0}}) && en) begin
              state_q <= STEP_X;
              busy_q  <= 1'b1;
            end
          end
        end
        STEP_X: begin
          shx_q   <= step_d;
          state_q <= STEP_Y;
        end
        STEP_Y: begin
          shy_q   <= step_d;
          state_q <= COMMIT;
        end
        COMMIT: begin
          sprx_q     <= shx_q.pos;
          dx_q       <= shx_q.vel;
          spry_q     <= shy_q.pos;
          dy_q       <= shy_q.vel;
          bounce_x_q <= shx_q.hit;
          bounce_y_q <= shy_q.hit;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sprx     = sprx_q;
  assign spry     = spry_q;
  assign dx       = dx_q;
  assign dy       = dy_q;
  assign bounce_x = bounce_x_q;
  assign bounce_y = bounce_y_q;
  assign busy     = busy_q;

endmodule

// File: doc/sprite_mover.md
Name: sprite_mover

Overview:
- Per-frame position controller for one hardware sprite.
- Produces the sprite's sprx/spry pair and steps it by a signed velocity once every FRAME_DIV frames, bouncing off the screen edges.
- Sits between the display timing generator (frame pulse) and the sprite engine's sprx/spry inputs.
- One shared single-axis step unit is time-multiplexed between X and Y. Updates commit atomically, so the sprite engine never sees a mixed old/new pair.

Parameters:
- CORDW, 16, signed coordinate width (bits)
- H_RES, 480, active horizontal pixels
- V_RES, 272, active vertical pixels
- SPR_W_PX, 64, on-screen sprite width (bitmap width × 2^scale)
- SPR_H_PX, 64, on-screen sprite height
- VELW, 6, signed velocity width (bits)
- FRAME_DIV, 1, update once every FRAME_DIV frames (≥1)

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- frame  in  1  one-cycle pulse at start of frame (blanking)
- en  in  1  motion enable; sampled on frame
- load  in  1  one-cycle pulse: load init values
- init_x  in  CORDW  signed initial x
- init_y  in  CORDW  signed initial y
- init_dx  in  VELW  signed initial x velocity
- init_dy  in  VELW  signed initial y velocity
- sprx  out  CORDW  signed sprite x (to sprite engine)
- spry  out  CORDW  signed sprite y
- dx  out  VELW  current x velocity
- dy  out  VELW  current y velocity
- bounce_x  out  1  one-cycle pulse: x edge hit this update
- bounce_y  out  1  one-cycle pulse: y edge hit this update
- busy  out  1  high while FSM not IDLE

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous, active-high (rst).
- Constants: MAX_X = H_RES−SPR_W_PX (416 at defaults); MAX_Y = V_RES−SPR_H_PX (208 at defaults).
- Reset values: sprx=0, spry=0, dx=0, dy=0, bounce_x=0, bounce_y=0, busy=0, frame divider count=0, state=IDLE.
- rst mid-update: returns to IDLE; no commit occurs.
- FSM states: IDLE → STEP_X → STEP_Y → COMMIT → IDLE, one cycle each.
- Divider: counts frame pulses, wrapping at FRAME_DIV−1. An update starts only on a frame pulse when the count is 0 and en=1.
- STEP_X: the step unit computes nx=sprx+dx at CORDW+1 bits (no overflow); the result and the new dx are held in shadow registers.
- STEP_Y: the same step unit computes the Y result, also held in shadow.
- COMMIT: sprx, spry, dx, dy update together. bounce_x/bounce_y pulse high for this single cycle only.
- Latency: frame to new sprx/spry visible is 3 cycles; busy is high for exactly those 3 cycles.
- Bounce rule (per axis, n=pos+vel):
  - n<0 → pos=0, vel=−vel, bounce=1.
  - n>MAX → pos=MAX, vel=−vel, bounce=1.
  - Otherwise pos=n, vel unchanged, bounce=0.
  - n==0 or n==MAX is not a bounce.
  - A velocity of 0 never bounces.
  - Negating the most-negative VELW value saturates to the largest positive value.
- load: takes priority over everything.
  - Sets sprx/spry/dx/dy from the init values on the next edge and forces IDLE, aborting any in-flight update with no commit and no bounce pulses.
  - Init positions are clamped to 0..MAX.
  - load also clears the divider count.
- Simultaneous frame and load: load wins; the frame is dropped.
- frame while busy: ignored. It does not advance the divider.
- en=0: the divider still advances; no update occurs; outputs hold.

Optional Feature:
- Macro: SPRITE_MOVER_WRAP_EN.
- Defined: edges wrap instead of bouncing. n<0 → pos=MAX; n>MAX → pos=0; velocity unchanged. bounce_x/bounce_y still pulse on each edge event.
- Undefined: bounce rule as above.

Decomposition:
- Package sprite_pkg holds:
  - state enum mover_state_t {IDLE, STEP_X, STEP_Y, COMMIT}
  - an edge-event struct {pos, vel, hit}
  - the mode selection derived from SPRITE_MOVER_WRAP_EN
- Sub-module sprite_axis_step:
  - combinational; inputs pos, vel, max; outputs next pos, next vel, hit
  - holds the bounce/wrap logic
  - instanced once in sprite_mover and muxed between X and Y

Test Plan (defaults unless noted):
- Straight move: load (100,50,+3,−2), en=1, one frame → after 3 cycles sprx=103, spry=48; busy high exactly 3 cycles; no bounce pulses.
- Right-edge bounce: load (414,10,+5,0), frame → sprx=416, dx=−5, bounce_x pulse one cycle; next frame → sprx=411.
- Top-edge bounce: load (10,1,0,−4), frame → spry=0, dy=+4, bounce_y=1. Exact landing: load y=4, dy=−4 → spry=0, no bounce.
- Divider: FRAME_DIV=3, dx=+1, 9 frames → sprx advances by 3, updating on frames 1, 4, 7. en=0 for 9 frames → no change.
- load mid-update: frame, then load (200,100,+1,+1) during STEP_Y → no commit; sprx=200, spry=100; bounce pulses stay 0.
- WRAP_EN build: load (415,0,+4,0), frame → sprx=0, dx=+4, bounce_x=1.
